// File: rtl/asip_pipe_pkg.sv
// asip_pipe_pkg: shared widths, skid-stage state encoding and control-field bit positions
package asip_pipe_pkg;
  localparam int N_DEF  = 32;
  localparam int V_DEF  = 20;
  localparam int L_DEF  = 8;
  localparam int CW_DEF = 8;
  localparam int AW_DEF = 5;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_e;
  // bit positions inside the packed control field
  localparam int REGWE  = 0;
  localparam int MEMWE  = 1;
  localparam int WBSEL  = 2;
  localparam int OPSRC  = 4;
  localparam int OPTYPE = 5;
endpackage

// File: rtl/pipe_payload_reg.sv
// pipe_payload_reg: load-enabled payload flop bank with synchronous reset to zero
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  always_ff @(posedge CLK)
    if (RST) o_q <= '0;
    else if (i_load) o_q <= i_d;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: elastic valid/ready pipeline stage with 2-entry skid buffer,
// flush, invalid-output masking and saturating backpressure counter
module pipe_stage_skid
  import asip_pipe_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int V  = V_DEF,
  parameter int L  = L_DEF,
  parameter int CW = CW_DEF,
  parameter int AW = AW_DEF,
  parameter int SW = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                flush_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [CW-1:0]       s_ctrl_i,
  input  logic [AW-1:0]       s_a3_i,
  input  logic [N-1:0]        s_scalar_i,
  input  logic [V-1:0][L-1:0] s_vector_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [CW-1:0]       m_ctrl_o,
  output logic [AW-1:0]       m_a3_o,
  output logic [N-1:0]        m_scalar_o,
  output logic [V-1:0][L-1:0] m_vector_o,
  output logic [1:0]          occupancy_o,
  output logic [SW-1:0]       stall_cycles_o
);
  localparam int PW = CW + AW + N + V * L;
  skid_state_e r_state, w_next;
  logic          w_in_fire, w_out_fire, w_load_main, w_load_skid, w_main_from_skid;
  logic [PW-1:0] w_s_pay, w_main_d, w_main_q, w_skid_q;
  logic [CW-1:0] w_m_ctrl;
  logic [AW-1:0] w_m_a3;
  logic [SW-1:0] r_stall;
  assign s_ready_o   = ~RST & (r_state != TWO);
  assign m_valid_o   = (r_state != EMPTY);
  assign occupancy_o = r_state;
  assign w_in_fire   = s_valid_i & s_ready_o;
  assign w_out_fire  = m_valid_o & m_ready_i;
  always_comb begin
    w_next           = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        w_load_main = w_in_fire;
        w_next      = w_in_fire ? ONE : EMPTY;
      end
      ONE: begin
        w_load_main = w_in_fire & w_out_fire;
        w_load_skid = w_in_fire & ~w_out_fire;
        w_next      = (w_in_fire & ~w_out_fire) ? TWO : (~w_in_fire & w_out_fire) ? EMPTY : ONE;
      end
      TWO: begin
        w_load_main      = w_out_fire;
        w_main_from_skid = 1'b1;
        w_next           = w_out_fire ? ONE : TWO;
      end
      default: w_next = EMPTY;
    endcase
    // flush wins over any accepted beat; the drained beat still leaves
    if (flush_i) w_next = EMPTY;
  end
  always_ff @(posedge CLK)
    if (RST) r_state <= EMPTY;
    else r_state <= w_next;
  always_ff @(posedge CLK)
    if (RST) r_stall <= '0;
    else if (m_valid_o & ~m_ready_i & ~&r_stall) r_stall <= r_stall + 1'b1;
  assign stall_cycles_o = r_stall;
  assign w_s_pay  = {s_ctrl_i, s_a3_i, s_scalar_i, s_vector_i};
  assign w_main_d = w_main_from_skid ? w_skid_q : w_s_pay;
  pipe_payload_reg #(.W(PW)) u_main (
    .CLK(CLK), .RST(RST), .i_load(w_load_main), .i_d(w_main_d), .o_q(w_main_q)
  );
  pipe_payload_reg #(.W(PW)) u_skid (
    .CLK(CLK), .RST(RST), .i_load(w_load_skid), .i_d(w_s_pay), .o_q(w_skid_q)
  );
  assign {w_m_ctrl, w_m_a3, m_scalar_o, m_vector_o} = w_main_q;
  assign m_ctrl_o = m_valid_o ? w_m_ctrl : '0;
  assign m_a3_o   = m_valid_o ? w_m_a3 : '0;
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed checks of handshake, skid ordering, flush, masking and stall saturation
module tb_pipe_stage_skid;
  logic                CLK = 1'b0;
  logic                RST, flush_i, s_valid_i, m_ready_i;
  logic [7:0]          s_ctrl_i;
  logic [4:0]          s_a3_i;
  logic [31:0]         s_scalar_i;
  logic [19:0][7:0]    s_vector_i;
  logic                s_ready_o, m_valid_o;
  logic [7:0]          m_ctrl_o;
  logic [4:0]          m_a3_o;
  logic [31:0]         m_scalar_o;
  logic [19:0][7:0]    m_vector_o, exp_vec;
  logic [1:0]          occupancy_o;
  logic [15:0]         stall_cycles_o;
  logic                s4_ready, s4_valid;
  logic [7:0]          s4_ctrl;
  logic [4:0]          s4_a3;
  logic [31:0]         s4_scalar;
  logic [19:0][7:0]    s4_vector;
  logic [1:0]          s4_occ;
  logic [3:0]          s4_stall;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_skid dut (
    .CLK(CLK), .RST(RST), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_ctrl_i(s_ctrl_i), .s_a3_i(s_a3_i),
    .s_scalar_i(s_scalar_i), .s_vector_i(s_vector_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_ctrl_o(m_ctrl_o), .m_a3_o(m_a3_o),
    .m_scalar_o(m_scalar_o), .m_vector_o(m_vector_o),
    .occupancy_o(occupancy_o), .stall_cycles_o(stall_cycles_o)
  );

  pipe_stage_skid #(.SW(4)) dut_sw4 (
    .CLK(CLK), .RST(RST), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s4_ready), .s_ctrl_i(s_ctrl_i), .s_a3_i(s_a3_i),
    .s_scalar_i(s_scalar_i), .s_vector_i(s_vector_i),
    .m_valid_o(s4_valid), .m_ready_i(m_ready_i), .m_ctrl_o(s4_ctrl), .m_a3_o(s4_a3),
    .m_scalar_o(s4_scalar), .m_vector_o(s4_vector),
    .occupancy_o(s4_occ), .stall_cycles_o(s4_stall)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; flush_i = 1'b0; s_valid_i = 1'b1; m_ready_i = 1'b0;
    s_ctrl_i = 8'h5A; s_a3_i = 5'd9; s_scalar_i = 32'h99; s_vector_i = '1;
    step();
    step();
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", s_ready_o); end
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", m_valid_o); end
    checks++; if (occupancy_o !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy_o); end
    checks++; if ({m_ctrl_o, m_a3_o, m_scalar_o, m_vector_o} !== '0) begin errors++; $display("FAIL reset_payload got nonzero scalar %h ctrl %h", m_scalar_o, m_ctrl_o); end
    checks++; if (stall_cycles_o !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles_o); end
    RST = 1'b0; s_valid_i = 1'b0;
    #1;
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", s_ready_o); end
  endtask

  task automatic test_stream();
    m_ready_i = 1'b1; s_ctrl_i = 8'h01; s_a3_i = 5'd1; s_vector_i = '0;
    for (int i = 1; i <= 4; i++) begin
      s_valid_i = 1'b1; s_scalar_i = 32'(i);
      step();
      checks++; if (m_valid_o !== 1'b1 || m_scalar_o !== 32'(i)) begin errors++; $display("FAIL stream_out[%0d] got v=%b %0d exp v=1 %0d", i, m_valid_o, m_scalar_o, i); end
      checks++; if (s_ready_o !== 1'b1 || occupancy_o !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got rdy=%b occ=%0d exp rdy=1 occ=1", i, s_ready_o, occupancy_o); end
    end
    s_valid_i = 1'b0;
    step();
    checks++; if (m_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", m_valid_o, occupancy_o); end
  endtask

  task automatic test_backpressure();
    m_ready_i = 1'b0; s_valid_i = 1'b1; s_scalar_i = 32'hA;
    step();
    s_scalar_i = 32'hB;
    step();
    checks++; if (occupancy_o !== 2'd2 || s_ready_o !== 1'b0) begin errors++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy_o, s_ready_o); end
    checks++; if (m_scalar_o !== 32'hA) begin errors++; $display("FAIL bp_head got %h exp a", m_scalar_o); end
    s_scalar_i = 32'hC;
    step();
    checks++; if (occupancy_o !== 2'd2 || m_scalar_o !== 32'hA) begin errors++; $display("FAIL bp_hold got occ=%0d %h exp occ=2 a", occupancy_o, m_scalar_o); end
    m_ready_i = 1'b1;
    step();
    checks++; if (m_scalar_o !== 32'hB || occupancy_o !== 2'd1) begin errors++; $display("FAIL bp_second got %h occ=%0d exp b occ=1", m_scalar_o, occupancy_o); end
    step();
    checks++; if (m_scalar_o !== 32'hC || m_valid_o !== 1'b1) begin errors++; $display("FAIL bp_third got %h v=%b exp c v=1", m_scalar_o, m_valid_o); end
    s_valid_i = 1'b0;
    step();
    checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL bp_nodup got v=%b %h exp v=0", m_valid_o, m_scalar_o); end
  endtask

  task automatic test_flush();
    m_ready_i = 1'b0; s_valid_i = 1'b1; s_scalar_i = 32'h11; s_ctrl_i = 8'h03; s_a3_i = 5'd2;
    step();
    checks++; if (m_scalar_o !== 32'h11 || m_ctrl_o !== 8'h03 || m_a3_o !== 5'd2) begin errors++; $display("FAIL flush_pre got %h ctrl %h a3 %0d exp 11 03 2", m_scalar_o, m_ctrl_o, m_a3_o); end
    flush_i = 1'b1; s_scalar_i = 32'h55;
    step();
    flush_i = 1'b0; s_valid_i = 1'b0;
    checks++; if (m_valid_o !== 1'b0 || occupancy_o !== 2'd0) begin errors++; $display("FAIL flush_empty got v=%b occ=%0d exp v=0 occ=0", m_valid_o, occupancy_o); end
    checks++; if (m_ctrl_o !== 8'h00 || m_a3_o !== 5'd0) begin errors++; $display("FAIL flush_mask got ctrl %h a3 %0d exp 00 0", m_ctrl_o, m_a3_o); end
    m_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (m_valid_o !== 1'b0) begin errors++; $display("FAIL flush_dropped[%0d] got v=%b %h exp v=0", i, m_valid_o, m_scalar_o); end
    end
  endtask

  task automatic test_stall();
    RST = 1'b1;
    step();
    RST = 1'b0; m_ready_i = 1'b0; s_valid_i = 1'b1; s_scalar_i = 32'h77;
    step();
    s_valid_i = 1'b0;
    checks++; if (stall_cycles_o !== 16'd0) begin errors++; $display("FAIL stall_start got %0d exp 0", stall_cycles_o); end
    repeat (10) step();
    checks++; if (stall_cycles_o !== 16'd10 || s4_stall !== 4'd10) begin errors++; $display("FAIL stall_10 got %0d sw4 %0d exp 10 10", stall_cycles_o, s4_stall); end
    repeat (10) step();
    checks++; if (stall_cycles_o !== 16'd20) begin errors++; $display("FAIL stall_20 got %0d exp 20", stall_cycles_o); end
    checks++; if (s4_stall !== 4'd15) begin errors++; $display("FAIL stall_sat got %0d exp 15", s4_stall); end
    flush_i = 1'b1; m_ready_i = 1'b1;
    step();
    flush_i = 1'b0; m_ready_i = 1'b0;
    repeat (2) step();
    checks++; if (stall_cycles_o !== 16'd20 || s4_stall !== 4'd15 || m_valid_o !== 1'b0) begin errors++; $display("FAIL stall_flush got %0d sw4 %0d v=%b exp 20 15 v=0", stall_cycles_o, s4_stall, m_valid_o); end
  endtask

  task automatic test_lanes();
    for (int k = 0; k < 20; k++) s_vector_i[k] = 8'(k + 1);
    exp_vec = s_vector_i;
    m_ready_i = 1'b0; s_valid_i = 1'b1; s_ctrl_i = 8'hFF; s_a3_i = 5'd7; s_scalar_i = 32'h1234;
    step();
    s_valid_i = 1'b0; s_vector_i = '0;
    checks++; if (m_vector_o[0] !== 8'h01 || m_vector_o[19] !== 8'h14) begin errors++; $display("FAIL lanes_ends got %h %h exp 01 14", m_vector_o[0], m_vector_o[19]); end
    checks++; if (m_vector_o !== exp_vec) begin errors++; $display("FAIL lanes_all got %h exp %h", m_vector_o, exp_vec); end
    checks++; if (m_ctrl_o !== 8'hFF || m_a3_o !== 5'd7) begin errors++; $display("FAIL lanes_ctrl got %h a3 %0d exp ff 7", m_ctrl_o, m_a3_o); end
    m_ready_i = 1'b1;
    step();
    checks++; if (m_valid_o !== 1'b0 || m_ctrl_o !== 8'h00 || m_a3_o !== 5'd0) begin errors++; $display("FAIL lanes_mask got v=%b ctrl %h a3 %0d exp 0 00 0", m_valid_o, m_ctrl_o, m_a3_o); end
    checks++; if (m_vector_o[19] !== 8'h14 || m_scalar_o !== 32'h1234) begin errors++; $display("FAIL lanes_unmasked got %h %h exp 14 1234", m_vector_o[19], m_scalar_o); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_stall();
    test_lanes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
